classificador_digito: RTL and testbench



---
 rtl/classificador_digito.sv | 150 +++++++++++++++
 tb/tb_classificador_digito.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/classificador_digito.sv
// Nearest-template classifier: sums each 11x11 difference array selected by digito_sel
// and reports the argmin digit. Optional rejection threshold: `CLASSIFICADOR_LIMIAR_EN.
module classificador_digito #(
  parameter int NUM_DIGITOS = 10,
  parameter int DIM         = 11,
  parameter int PIXEL_W     = 8,
  parameter int LIMIAR      = 12000
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 start,
  input  logic [DIM-1:0][DIM-1:0][PIXEL_W-1:0] diff_pixel,
  output logic [3:0]                           digito_sel,
  output logic                                 busy,
  output logic                                 done,
  output logic [3:0]                           digito,
  output logic [14:0]                          distancia
);

  localparam int DIST_W = 15;
  localparam int POS_W  = 4;
  localparam int IDX_W  = 4;

  localparam logic [POS_W-1:0]  POS_ULTIMA   = POS_W'(DIM - 1);
  localparam logic [IDX_W-1:0]  IDX_ULTIMO   = IDX_W'(NUM_DIGITOS - 1);
  localparam logic [DIST_W-1:0] DIST_MAXIMA  = '1;

  typedef enum logic [1:0] {
    IDLE,
    ACUM,
    COMPARA,
    FIM
  } estado_t;

  estado_t             estado_q;
  logic [DIST_W-1:0]   acc_q;
  logic [DIST_W-1:0]   melhor_q;
  logic [IDX_W-1:0]    melhor_idx_q;
  logic [POS_W-1:0]    lin_q;
  logic [POS_W-1:0]    col_q;
  logic [IDX_W-1:0]    sel_q;
  logic                busy_q;
  logic                done_q;
  logic [IDX_W-1:0]    digito_q;
  logic [DIST_W-1:0]   distancia_q;

  logic [PIXEL_W-1:0]  pixel_atual;
  logic [DIST_W-1:0]   acc_d;
  logic                novo_melhor;
  logic [DIST_W-1:0]   melhor_d;
  logic [IDX_W-1:0]    melhor_idx_d;
  logic [IDX_W-1:0]    digito_d;

  assign pixel_atual  = diff_pixel[lin_q][col_q];
  assign acc_d        = acc_q + {{(DIST_W-PIXEL_W){1'b0}}, pixel_atual};

  // Strict less-than keeps the lower index on ties, since digits are scanned upward.
  assign novo_melhor  = (acc_q < melhor_q);
  assign melhor_d     = novo_melhor ? acc_q : melhor_q;
  assign melhor_idx_d = novo_melhor ? sel_q : melhor_idx_q;

`ifdef CLASSIFICADOR_LIMIAR_EN
  assign digito_d = (melhor_d > DIST_W'(LIMIAR)) ? 4'hF : melhor_idx_d;
`else
  assign digito_d = melhor_idx_d;
`endif

  // The result registers are loaded on the edge that enters FIM, so digito and
  // distancia are already valid during the done cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      estado_q     <= IDLE;
      acc_q        <= '0;
      melhor_q     <= DIST_MAXIMA;
      melhor_idx_q <= '0;
      lin_q        <= '0;
      col_q        <= '0;
      sel_q        <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      digito_q     <= '0;
      distancia_q  <= '0;
    end else begin
      // NOTE: non-blocking assignments here so every register samples the pre-edge
      // values; blocking ones would let later statements see already-updated state.
      done_q <= 1'b0;
      unique case (estado_q)
        IDLE: begin
          if (start) begin
            acc_q        <= '0;
            lin_q        <= '0;
            col_q        <= '0;
            sel_q        <= '0;
            melhor_q     <= DIST_MAXIMA;
            melhor_idx_q <= '0;
            busy_q       <= 1'b1;
            estado_q     <= ACUM;
          end
        end

        ACUM: begin
          acc_q <= acc_d;
          if (col_q == POS_ULTIMA) begin
            col_q <= '0;
            if (lin_q == POS_ULTIMA) begin
              lin_q    <= '0;
              estado_q <= COMPARA;
            end else begin
              lin_q <= lin_q + 4'd1;
            end
          end else begin
            col_q <= col_q + 4'd1;
          end
        end

        COMPARA: begin
          melhor_q     <= melhor_d;
          melhor_idx_q <= melhor_idx_d;
          if (sel_q == IDX_ULTIMO) begin
            digito_q    <= digito_d;
            distancia_q <= melhor_d;
            done_q      <= 1'b1;
            estado_q    <= FIM;
          end else begin
            sel_q    <= sel_q + 4'd1;
            acc_q    <= '0;
            lin_q    <= '0;
            col_q    <= '0;
            estado_q <= ACUM;
          end
        end

        FIM: begin
          sel_q    <= '0;
          busy_q   <= 1'b0;
          estado_q <= IDLE;
        end

        default: estado_q <= IDLE;
      endcase
    end
  end

  assign digito_sel = sel_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign digito     = digito_q;
  assign distancia  = distancia_q;

endmodule

// File: tb/tb_classificador_digito.sv
// Directed bench for classificador_digito: a behavioural template source drives
// diff_pixel from digito_sel; cycle k is the clock period following edge k-1.
module tb_classificador_digito;

  logic                       clk = 1'b0;
  logic                       rst_n;
  logic                       start;
  logic [10:0][10:0][7:0]     diff_pixel;
  logic [3:0]                 digito_sel;
  logic                       busy;
  logic                       done;
  logic [3:0]                 digito;
  logic [14:0]                distancia;

  int          mode;
  int          n_vec = 0;
  int          n_err = 0;
  logic [3:0]  mdl_dig;
  logic [14:0] mdl_dist;

  always #5 clk = ~clk;

  classificador_digito dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .diff_pixel (diff_pixel),
    .digito_sel (digito_sel),
    .busy       (busy),
    .done       (done),
    .digito     (digito),
    .distancia  (distancia)
  );

  // Template source: uniform value per digit, chosen by the current mode.
  function automatic logic [7:0] pix_val(input int m, input logic [3:0] sel);
    case (m)
      0:       return (sel == 4'd8) ? 8'd0 : 8'd1;
      1:       return 8'd5;
      2:       return (sel == 4'd9) ? 8'd254 : 8'd255;
      3:       return 8'd100;
      default: return 8'd0;
    endcase
  endfunction

  always_comb begin
    for (int l = 0; l < 11; l++)
      for (int c = 0; c < 11; c++)
        diff_pixel[l][c] = pix_val(mode, digito_sel);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Entered at a negedge; start is sampled at the next edge (edge 0).
  task automatic do_run(input string tag, input int m, input logic [3:0] exp_dig,
                        input logic [14:0] exp_dist, input int pulse_a, input int pulse_b,
                        input int abort_at);
    int          dones    = 0;
    int          done_cyc = -1;
    int          busy_bad = 0;
    int          sel_bad  = 0;
    int          idle_bad = 0;
    logic [3:0]  dig_at_done  = 4'd0;
    logic [14:0] dist_at_done = 15'd0;
    logic        exp_busy;
    logic [3:0]  exp_sel;
    mode  = m;
    start = 1'b1;
    for (int cyc = 1; cyc <= 1230; cyc++) begin
      @(negedge clk);
      start = (cyc == pulse_a) || (cyc == pulse_b);
      if (cyc == abort_at) begin
        start = 1'b0;
        rst_n = 1'b0;
        #1;
        chk({tag, "_abort_busy"}, 32'(busy), 32'd0);
        chk({tag, "_abort_sel"}, 32'(digito_sel), 32'd0);
        chk({tag, "_abort_digito"}, 32'(digito), 32'd0);
        chk({tag, "_abort_dist"}, 32'(distancia), 32'd0);
        chk({tag, "_abort_no_done_before"}, 32'(dones), 32'd0);
        repeat (3) begin
          @(negedge clk);
          if (done !== 1'b0 || busy !== 1'b0) idle_bad++;
        end
        rst_n = 1'b1;
        repeat (3) begin
          @(negedge clk);
          if (done !== 1'b0 || busy !== 1'b0) idle_bad++;
        end
        chk({tag, "_abort_stays_idle"}, 32'(idle_bad), 32'd0);
        mdl_dig  = 4'd0;
        mdl_dist = 15'd0;
        return;
      end
      exp_busy = (cyc >= 1) && (cyc <= 1221);
      if (busy !== exp_busy) busy_bad++;
      if (cyc <= 1220) begin
        exp_sel = 4'((cyc - 1) / 122);
        if (digito_sel !== exp_sel) sel_bad++;
      end else if (cyc >= 1222) begin
        if (digito_sel !== 4'd0) sel_bad++;
      end
      if (done === 1'b1) begin
        dones++;
        done_cyc     = cyc;
        dig_at_done  = digito;
        dist_at_done = distancia;
      end
      if (cyc == 600) begin
        chk({tag, "_hold_digito"}, 32'(digito), 32'(mdl_dig));
        chk({tag, "_hold_dist"}, 32'(distancia), 32'(mdl_dist));
      end
    end
    chk({tag, "_done_count"}, 32'(dones), 32'd1);
    chk({tag, "_done_cycle"}, 32'(done_cyc), 32'd1221);
    chk({tag, "_busy_trace_errs"}, 32'(busy_bad), 32'd0);
    chk({tag, "_sel_trace_errs"}, 32'(sel_bad), 32'd0);
    chk({tag, "_digito_at_done"}, 32'(dig_at_done), 32'(exp_dig));
    chk({tag, "_dist_at_done"}, 32'(dist_at_done), 32'(exp_dist));
    chk({tag, "_digito_after"}, 32'(digito), 32'(exp_dig));
    chk({tag, "_dist_after"}, 32'(distancia), 32'(exp_dist));
    mdl_dig  = exp_dig;
    mdl_dist = exp_dist;
  endtask

  initial begin
    logic [3:0] lim_dig;
    rst_n    = 1'b0;
    start    = 1'b0;
    mode     = 1;
    mdl_dig  = 4'd0;
    mdl_dist = 15'd0;
    repeat (2) @(negedge clk);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    chk("reset_sel", 32'(digito_sel), 32'd0);
    chk("reset_digito", 32'(digito), 32'd0);
    chk("reset_dist", 32'(distancia), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Digit 8 all zeros, others 1 per pixel; extra starts at 300 and 1221 ignored.
    do_run("sel8", 0, 4'd8, 15'd0, 300, 1221, 0);
    // Five per pixel everywhere: tie resolves to the lowest index, 121*5.
    do_run("tie", 1, 4'd0, 15'd605, 0, 0, 0);
    // 255 everywhere except digit 9 at 254: 121*254, no accumulator wrap.
    do_run("max", 2, 4'd9, 15'd30734, 0, 0, 0);
`ifdef CLASSIFICADOR_LIMIAR_EN
    lim_dig = 4'hF;
`else
    lim_dig = 4'd0;
`endif
    // 100 per pixel: 12100 exceeds the 12000 threshold when it is built in.
    do_run("limiar", 3, lim_dig, 15'd12100, 0, 0, 0);
    // Reset at cycle 500 aborts and clears the previous result.
    do_run("abort", 0, 4'd8, 15'd0, 0, 0, 500);
    // A fresh run after the abort completes normally.
    do_run("post_abort", 2, 4'd9, 15'd30734, 0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
